// File: rtl/f_pc_ras_pkg.sv
// Shared next-PC encodings and default vectors for the F-stage PC unit.
// The D-stage controller imports the same npc_sel_e encodings.
package f_pc_ras_pkg;

  localparam int unsigned NPC_SEL_W = 3;

  typedef enum logic [NPC_SEL_W-1:0] {
    NPC_ADD4 = 3'd0,
    NPC_BEQ  = 3'd1,
    NPC_JAL  = 3'd2,
    NPC_JR   = 3'd3,
    NPC_BNE  = 3'd4,
    NPC_BLEZ = 3'd5,
    NPC_BGTZ = 3'd6,
    NPC_JALR = 3'd7
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  // Calls that record a return address on the RAS.
  function automatic logic is_link(input npc_sel_e sel);
    return (sel == NPC_JAL) || (sel == NPC_JALR);
  endfunction

endpackage

// File: rtl/f_pc_ras_ras_stack.sv
// Return-address stack: circular buffer with wrapping pointer and saturating count.
// A full push overwrites the oldest entry; a pop on empty changes nothing.
module ras_stack
  import f_pc_ras_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic [WIDTH-1:0]         top_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ptr_q addresses the next free slot, so the top sits one below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_idx];
  assign count_o = cnt_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/f_pc_ras.sv
// F-stage PC register with branch/jump next-PC selection, exception redirects
// and a return-address-stack checker that flags jr $ra target mismatches.
module f_pc_ras
  import f_pc_ras_pkg::*;
#(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEFAULT),
  parameter logic [WIDTH-1:0] HANDLER_PC = WIDTH'(HANDLER_PC_DEFAULT),
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         req,
  input  logic                         eret,
  input  logic [WIDTH-1:0]             epc,
  input  logic                         d_valid,
  input  logic [NPC_SEL_W-1:0]         d_npc_sel,
  input  logic                         d_rs_is_ra,
  input  logic [15:0]                  d_imm16,
  input  logic [25:0]                  d_imm26,
  input  logic [WIDTH-1:0]             d_rd1,
  input  logic [WIDTH-1:0]             d_rd2,
  input  logic [WIDTH-1:0]             d_pc,
  output logic [WIDTH-1:0]             f_pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_hit,
  output logic                         ras_miss
);

  npc_sel_e         sel;
  logic [WIDTH-1:0] pc_q, pc_d, pc_plus4, br_tgt, j_tgt, dec_npc, ras_top;
  logic             rs_eq, rs_lez, taken, upd, push, pop;
  logic             hit_q, hit_d, miss_q, miss_d;

  assign sel      = npc_sel_e'(d_npc_sel);
  assign pc_plus4 = pc_q + WIDTH'(4);
  assign br_tgt   = d_pc + WIDTH'(4) + {{(WIDTH-18){d_imm16[15]}}, d_imm16, 2'b00};
  assign j_tgt    = {d_pc[WIDTH-1:28], d_imm26, 2'b00};
  assign rs_eq    = (d_rd1 == d_rd2);
  assign rs_lez   = d_rd1[WIDTH-1] || (d_rd1 == '0);

  // Decoded next PC; bubbles and untaken branches fall through to f_pc + 4.
  always_comb begin
    taken   = 1'b0;
    dec_npc = pc_plus4;
    if (d_valid) begin
      case (sel)
        NPC_BEQ:          taken   = rs_eq;
        NPC_BNE:          taken   = !rs_eq;
        NPC_BLEZ:         taken   = rs_lez;
        NPC_BGTZ:         taken   = !rs_lez;
        NPC_JAL:          dec_npc = j_tgt;
        NPC_JR, NPC_JALR: dec_npc = d_rd1;
        default:          ;
      endcase
    end
    if (taken) dec_npc = br_tgt;
  end

  always_comb begin
    pc_d = dec_npc;
    if (req)        pc_d = HANDLER_PC;
    else if (eret)  pc_d = epc;
    else if (stall) pc_d = pc_q;
  end

  // The RAS only moves when the decoded PC is actually taken for a real instruction.
  assign upd  = d_valid && !req && !eret && !stall;
  assign push = upd && is_link(sel);
  assign pop  = upd && (sel == NPC_JR) && d_rs_is_ra;

  assign hit_d  = pop && (ras_count != '0) && (ras_top == d_rd1);
  assign miss_d = pop && !hit_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (d_pc + WIDTH'(8)),
    .top_o       (ras_top),
    .count_o     (ras_count)
  );

  assign f_pc     = pc_q;
  assign ras_hit  = hit_q;
  assign ras_miss = miss_q;

endmodule

// File: tb/tb_f_pc_ras.sv
// Scoreboard bench for f_pc_ras: a behavioural PC/RAS model queues the expected
// outputs per driven cycle, and each scenario task pops and compares them.
module tb_f_pc_ras;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret, d_valid, d_rs_is_ra;
  logic [31:0] epc, d_rd1, d_rd2, d_pc;
  logic [2:0]  d_npc_sel;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] f_pc;
  logic [2:0]  ras_count;
  logic        ras_hit, ras_miss;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rst, stall, req, eret;
    logic [31:0] epc;
    logic        valid;
    logic [2:0]  sel;
    logic [31:0] pc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rd1, rd2;
    logic        ra;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        hit, miss;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  f_pc_ras dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req        (req),
    .eret       (eret),
    .epc        (epc),
    .d_valid    (d_valid),
    .d_npc_sel  (d_npc_sel),
    .d_rs_is_ra (d_rs_is_ra),
    .d_imm16    (d_imm16),
    .d_imm26    (d_imm26),
    .d_rd1      (d_rd1),
    .d_rd2      (d_rd2),
    .d_pc       (d_pc),
    .f_pc       (f_pc),
    .ras_count  (ras_count),
    .ras_hit    (ras_hit),
    .ras_miss   (ras_miss)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t dj(input logic [2:0] sel, input logic [31:0] pc,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic ra);
    stim_t s;
    s       = '0;
    s.valid = 1'b1;
    s.sel   = sel;
    s.pc    = pc;
    s.i16   = 16'hFFFC;
    s.i26   = 26'h0000C10;
    s.rd1   = rd1;
    s.rd2   = rd2;
    s.ra    = ra;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst; stall = s.stall; req = s.req; eret = s.eret; epc = s.epc;
    d_valid = s.valid; d_npc_sel = s.sel; d_pc = s.pc; d_imm16 = s.i16;
    d_imm26 = s.i26; d_rd1 = s.rd1; d_rd2 = s.rd2; d_rs_is_ra = s.ra;
  endtask

  // Model the edge for the currently driven inputs, queue the result, then clock.
  task automatic apply();
    exp_t        e;
    logic [31:0] npc, bt, jt, top;
    e.hit  = 1'b0;
    e.miss = 1'b0;
    bt  = d_pc + 32'd4 + (32'($signed(d_imm16)) << 2);
    jt  = {d_pc[31:28], d_imm26, 2'b00};
    npc = m_pc + 32'd4;
    if (d_valid) begin
      case (d_npc_sel)
        3'd1: if (d_rd1 == d_rd2) npc = bt;
        3'd4: if (d_rd1 != d_rd2) npc = bt;
        3'd5: if ($signed(d_rd1) <= 0) npc = bt;
        3'd6: if ($signed(d_rd1) > 0) npc = bt;
        3'd2: npc = jt;
        3'd3, 3'd7: npc = d_rd1;
        default: ;
      endcase
    end
    if (reset) begin
      m_pc = 32'h0000_3000;
      m_ras.delete();
    end else if (req) begin
      m_pc = 32'h0000_4180;
    end else if (eret) begin
      m_pc = epc;
    end else if (!stall) begin
      m_pc = npc;
      if (d_valid && (d_npc_sel == 3'd2 || d_npc_sel == 3'd7)) begin
        if (m_ras.size() == 4) void'(m_ras.pop_front());
        m_ras.push_back(d_pc + 32'd8);
      end else if (d_valid && d_npc_sel == 3'd3 && d_rs_is_ra) begin
        if (m_ras.size() == 0) e.miss = 1'b1;
        else begin
          top = m_ras.pop_back();
          if (top == d_rd1) e.hit = 1'b1;
          else e.miss = 1'b1;
        end
      end
    end
    e.pc  = m_pc;
    e.cnt = 3'(m_ras.size());
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      stim_t s;
      s = idle();
      s.rst = (i < 2);
      drive(s);
      apply();
      e = sb_q.pop_front();
      checks++;
      if (f_pc !== e.pc) begin
        errors++; $display("FAIL reset[%0d] f_pc: got %h want %h", i, f_pc, e.pc);
      end
      checks++;
      if ({ras_count, ras_hit, ras_miss} !== {e.cnt, e.hit, e.miss}) begin
        errors++;
        $display("FAIL reset[%0d] ras: got cnt=%0d hit=%b miss=%b want cnt=%0d hit=%b miss=%b",
                 i, ras_count, ras_hit, ras_miss, e.cnt, e.hit, e.miss);
      end
      if (i == 1) begin
        checks++;
        if (f_pc !== 32'h0000_3000 || ras_count !== 3'd0) begin
          errors++; $display("FAIL reset_value: got f_pc=%h cnt=%0d want 00003000 cnt=0", f_pc, ras_count);
        end
      end
    end
  endtask

  task automatic test_branches();
    exp_t  e;
    stim_t t[$];
    t.push_back(dj(3'd1, 32'h3010, 32'd5, 32'd5, 1'b0));          // BEQ taken
    t.push_back(dj(3'd4, 32'h3010, 32'd5, 32'd5, 1'b0));          // BNE not taken
    t.push_back(dj(3'd5, 32'h3010, 32'h8000_0000, 32'd0, 1'b0));  // BLEZ taken
    t.push_back(dj(3'd6, 32'h3010, 32'd0, 32'd0, 1'b0));          // BGTZ not taken
    t.push_back(dj(3'd6, 32'h3010, 32'd1, 32'd0, 1'b0));          // BGTZ taken
    t.push_back(dj(3'd5, 32'h3010, 32'd1, 32'd0, 1'b0));          // BLEZ not taken
    t.push_back(dj(3'd1, 32'h3010, 32'd5, 32'd6, 1'b0));          // BEQ not taken
    t.push_back(dj(3'd0, 32'h3010, 32'd5, 32'd5, 1'b0));          // ADD4
    foreach (t[i]) begin
      drive(t[i]);
      apply();
      e = sb_q.pop_front();
      checks++;
      if (f_pc !== e.pc) begin
        errors++; $display("FAIL branch[%0d] f_pc: got %h want %h", i, f_pc, e.pc);
      end
      if (i == 0) begin
        checks++;
        if (f_pc !== 32'h0000_3004) begin
          errors++; $display("FAIL beq_taken: got %h want 00003004", f_pc);
        end
      end
    end
  endtask

  task automatic test_call_return();
    exp_t  e;
    stim_t t[$];
    t.push_back(dj(3'd2, 32'h3020, 32'd0, 32'd0, 1'b0));          // JAL pushes 3028
    t.push_back(idle());
    t.push_back(dj(3'd3, 32'h3044, 32'h3028, 32'd0, 1'b1));       // jr $ra hit
    t.push_back(idle());
    t.push_back(dj(3'd2, 32'h3020, 32'd0, 32'd0, 1'b0));
    t.push_back(dj(3'd3, 32'h3044, 32'h3000, 32'd0, 1'b1));       // jr $ra miss
    t.push_back(dj(3'd2, 32'h3020, 32'd0, 32'd0, 1'b0));
    t.push_back(dj(3'd3, 32'h3044, 32'h3100, 32'd0, 1'b0));       // jr non-ra: RAS untouched
    t.push_back(idle());
    foreach (t[i]) begin
      drive(t[i]);
      apply();
      e = sb_q.pop_front();
      checks++;
      if (f_pc !== e.pc) begin
        errors++; $display("FAIL call[%0d] f_pc: got %h want %h", i, f_pc, e.pc);
      end
      checks++;
      if ({ras_count, ras_hit, ras_miss} !== {e.cnt, e.hit, e.miss}) begin
        errors++;
        $display("FAIL call[%0d] ras: got cnt=%0d hit=%b miss=%b want cnt=%0d hit=%b miss=%b",
                 i, ras_count, ras_hit, ras_miss, e.cnt, e.hit, e.miss);
      end
      if (i == 2) begin
        checks++;
        if (ras_hit !== 1'b1 || ras_miss !== 1'b0 || ras_count !== 3'd0) begin
          errors++; $display("FAIL jr_hit: got hit=%b miss=%b cnt=%0d want 1 0 0", ras_hit, ras_miss, ras_count);
        end
      end
      if (i == 5) begin
        checks++;
        if (ras_miss !== 1'b1 || ras_hit !== 1'b0) begin
          errors++; $display("FAIL jr_miss: got hit=%b miss=%b want 0 1", ras_hit, ras_miss);
        end
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) drive(dj(3'd2, 32'h3100 + 32'(16 * i), 32'd0, 32'd0, 1'b0));
      else drive(dj(3'd3, 32'h3400, 32'h3108 + 32'(16 * (11 - i)), 32'd0, 1'b1));
      apply();
      e = sb_q.pop_front();
      checks++;
      if ({f_pc, ras_count, ras_hit, ras_miss} !== {e.pc, e.cnt, e.hit, e.miss}) begin
        errors++;
        $display("FAIL overflow[%0d]: got pc=%h cnt=%0d hit=%b miss=%b want pc=%h cnt=%0d hit=%b miss=%b",
                 i, f_pc, ras_count, ras_hit, ras_miss, e.pc, e.cnt, e.hit, e.miss);
      end
      if (i == 5) begin
        checks++;
        if (ras_count !== 3'd4) begin
          errors++; $display("FAIL ras_saturate: got %0d want 4", ras_count);
        end
      end
      if (i >= 10) begin
        checks++;
        if (ras_miss !== 1'b1) begin
          errors++; $display("FAIL pop_empty[%0d]: got miss=%b want 1", i, ras_miss);
        end
      end
    end
  endtask

  task automatic test_req_eret();
    exp_t  e;
    stim_t t[$];
    stim_t s;
    s = dj(3'd2, 32'h3020, 32'd0, 32'd0, 1'b0);
    s.req = 1'b1; s.eret = 1'b1; s.epc = 32'h3040;
    t.push_back(s);
    s = idle(); s.eret = 1'b1; s.epc = 32'h3040;
    t.push_back(s);
    s = dj(3'd2, 32'h3020, 32'd0, 32'd0, 1'b0); s.eret = 1'b1; s.epc = 32'h3060;
    t.push_back(s);
    foreach (t[i]) begin
      drive(t[i]);
      apply();
      e = sb_q.pop_front();
      checks++;
      if ({f_pc, ras_count} !== {e.pc, e.cnt}) begin
        errors++; $display("FAIL req_eret[%0d]: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, f_pc, ras_count, e.pc, e.cnt);
      end
    end
    checks++;
    if (f_pc !== 32'h3060 || ras_count !== 3'd0) begin
      errors++; $display("FAIL eret_no_push: got pc=%h cnt=%0d want 00003060 0", f_pc, ras_count);
    end
  endtask

  task automatic test_stall();
    exp_t        e;
    stim_t       s;
    logic [31:0] pc0;
    int          c0;
    pc0 = m_pc;
    c0  = m_ras.size();
    for (int i = 0; i < 6; i++) begin
      s = dj(3'd2, 32'h3020, 32'd0, 32'd0, 1'b0);
      s.stall = (i < 3);
      if (i == 5) s = idle();
      drive(s);
      apply();
      e = sb_q.pop_front();
      checks++;
      if ({f_pc, ras_count, ras_hit, ras_miss} !== {e.pc, e.cnt, e.hit, e.miss}) begin
        errors++;
        $display("FAIL stall[%0d]: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, f_pc, ras_count, e.pc, e.cnt);
      end
      if (i < 3) begin
        checks++;
        if (f_pc !== pc0 || ras_count !== 3'(c0)) begin
          errors++; $display("FAIL stall_hold[%0d]: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, f_pc, ras_count, pc0, c0);
        end
      end
    end
    checks++;
    if (ras_count !== 3'(c0 + 2)) begin
      errors++; $display("FAIL stall_push_once: got cnt=%0d want %0d", ras_count, c0 + 2);
    end
    s = dj(3'd2, 32'h3020, 32'd0, 32'd0, 1'b0);
    s.stall = 1'b1; s.rst = 1'b1;
    drive(s);
    apply();
    e = sb_q.pop_front();
    checks++;
    if ({f_pc, ras_count, ras_hit, ras_miss} !== {e.pc, e.cnt, e.hit, e.miss} ||
        f_pc !== 32'h3000 || ras_count !== 3'd0) begin
      errors++; $display("FAIL reset_in_stall: got pc=%h cnt=%0d want 00003000 0", f_pc, ras_count);
    end
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    stim_t t[$];
    t.push_back(dj(3'd2, 32'h3200, 32'd0, 32'd0, 1'b0));          // JAL  -> 3208
    t.push_back(dj(3'd7, 32'h3300, 32'h3500, 32'd0, 1'b0));       // JALR -> 3308
    t.push_back(dj(3'd3, 32'h3504, 32'h3308, 32'd0, 1'b1));       // hit
    t.push_back(dj(3'd3, 32'h3504, 32'h1234, 32'd0, 1'b1));       // miss, still pops
    t.push_back(dj(3'd3, 32'h3504, 32'h3208, 32'd0, 1'b1));       // empty -> miss
    t.push_back(idle());
    foreach (t[i]) begin
      drive(t[i]);
      apply();
      e = sb_q.pop_front();
      checks++;
      if ({f_pc, ras_count, ras_hit, ras_miss} !== {e.pc, e.cnt, e.hit, e.miss}) begin
        errors++;
        $display("FAIL b2b[%0d]: got pc=%h cnt=%0d hit=%b miss=%b want pc=%h cnt=%0d hit=%b miss=%b",
                 i, f_pc, ras_count, ras_hit, ras_miss, e.pc, e.cnt, e.hit, e.miss);
      end
      checks++;
      if (ras_hit === 1'b1 && ras_miss === 1'b1) begin
        errors++; $display("FAIL b2b_exclusive[%0d]: got hit=1 miss=1 want at most one", i);
      end
    end
  endtask

  initial begin
    m_pc = 32'h0;
    drive(idle());
    reset = 1'b1;
    test_reset();
    test_branches();
    test_call_return();
    test_overflow();
    test_req_eret();
    test_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_pc_ras.md
# f_pc_ras

Fetch-stage program-counter unit for the pipelined MIPS core, replacing the combinational next-PC selector. It owns the architectural F-stage PC register and computes the next PC from D-stage branch/jump decode, including condition evaluation. It also handles exception entry, `eret` return and stall holds. A parametrised return-address stack (RAS) checks every `jr $ra` target against the recorded call site and flags mismatches to the debug/trace logic.

## Interface
Parameters:
- `WIDTH`, 32: PC/data width.
- `RESET_PC`, 32'h0000_3000: PC after reset.
- `HANDLER_PC`, 32'h0000_4180: exception entry address.
- `RAS_DEPTH`, 4: RAS entries; a power of 2, at least 2.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `stall`, in, 1: hold the PC and RAS; the D instruction replays.
- `req`, in, 1: exception/interrupt request; redirect to `HANDLER_PC`.
- `eret`, in, 1: return from exception; redirect to `epc`.
- `epc`, in, WIDTH: return target, from CP0.
- `d_valid`, in, 1: the D-stage instruction is real (not a bubble).
- `d_npc_sel`, in, 3: next-PC kind. 0 ADD4, 1 BEQ, 2 JAL, 3 JR, 4 BNE, 5 BLEZ, 6 BGTZ, 7 JALR.
- `d_rs_is_ra`, in, 1: the rs field of the D instruction is 31.
- `d_imm16`, in, 16: branch offset.
- `d_imm26`, in, 26: jump index.
- `d_rd1`, in, WIDTH: forwarded rs value.
- `d_rd2`, in, WIDTH: forwarded rt value.
- `d_pc`, in, WIDTH: PC of the D-stage instruction.
- `f_pc`, out, WIDTH: current fetch PC (registered).
- `ras_count`, out, $clog2(RAS_DEPTH)+1: number of valid RAS entries.
- `ras_hit`, out, 1: registered pulse; a `jr $ra` matched the RAS top.
- `ras_miss`, out, 1: registered pulse; a `jr $ra` mismatched, or the RAS was empty.

## Operation
- Branch target: `d_pc + 4 + (sext(d_imm16) << 2)`, modulo 2^WIDTH.
- Jump target: `{d_pc[WIDTH-1:28], d_imm26, 2'b00}`.
- Register jump target: `d_rd1` for JR and JALR.
- Conditions are signed compares:
  - BEQ: rd1 == rd2.
  - BNE: rd1 != rd2.
  - BLEZ: rd1 ≤ 0.
  - BGTZ: rd1 > 0.
- A branch that is not taken, ADD4, and `d_valid=0` all select `f_pc + 4`.
- Next-PC priority:
  1. `reset` loads `RESET_PC`.
  2. `req` loads `HANDLER_PC`.
  3. `eret` loads `epc`.
  4. `stall` holds `f_pc`.
  5. Otherwise the decoded next PC.
- RAS updates happen only when the next PC is the decoded next PC and `d_valid=1`:
  - JAL or JALR pushes `d_pc + 8`.
  - JR with `d_rs_is_ra=1` pops.
  - JR with `d_rs_is_ra=0` leaves the RAS unchanged.
- Pop check, registered into the next cycle:
  - Count > 0 and top == `d_rd1`: `ras_hit=1`.
  - Count > 0 and top ≠ `d_rd1`: `ras_miss=1`.
  - Count == 0: `ras_miss=1`, and the pointer and count are unchanged.
  - On a mismatch the entry is still popped.
- Push when full: circular overwrite of the oldest entry; count saturates at `RAS_DEPTH`; the pointer wraps modulo `RAS_DEPTH`.
- The RAS never alters the fetch PC. It is a checker only.
- Misaligned targets pass through unchanged. AdEL detection lives in the F-stage exception logic.

## Timing
- Reset values:
  - `f_pc = RESET_PC`.
  - `ras_count = 0`.
  - `ras_hit = 0`, `ras_miss = 0`.
  - RAS pointer = 0. Entry contents are don't-care.
- Latency: one cycle. The next PC computed in cycle n appears on `f_pc` in cycle n+1. The branch delay slot is preserved: the instruction fetched while the branch is in D always issues.
- `ras_hit` and `ras_miss` are single-cycle pulses in the cycle after the pop. They are never high together.
- `req` and `eret` in the same cycle: `req` wins. Both suppress the RAS update of the D instruction.
- `stall` with a D-stage JAL: no push. The push happens exactly once, in the cycle the stall releases.
- `reset` asserted mid-sequence clears the RAS and the pulses on the next edge, regardless of other inputs.

## Structure
- A shared package holds:
  - the `d_npc_sel` encodings (ADD4 … JALR);
  - `RESET_PC_DEFAULT` and `HANDLER_PC_DEFAULT`.
  
  The D-stage controller imports the same encodings.
- One sub-module, `ras_stack`, is the RAS. It has a circular buffer, a pointer, a saturating count, push/pop inputs, and a top output.
- The top level contains the condition compare, the target adders, the priority mux and the PC register.

## Test plan
- Reset, then free-run with `d_valid=0`: `f_pc` = 0x3000, 0x3004, 0x3008; `ras_count=0`.
- BEQ taken:
  - Stimulus: `d_pc=0x3010`, imm16=0xFFFC, rd1=rd2=5.
  - Required: next `f_pc=0x3004`.
  - Same with BNE (not taken): `f_pc+4`.
  - BLEZ with rd1=0x8000_0000: taken. BGTZ with rd1=0: not taken.
- JAL at `d_pc=0x3020`:
  - Required: pushes 0x3028 and `ras_count=1`.
  - Later, JR with `d_rs_is_ra=1`, rd1=0x3028: `ras_hit` pulses one cycle, count becomes 0.
  - Repeat with rd1=0x3000: `ras_miss` pulses.
- `RAS_DEPTH=4`: six JALs, then six `jr $ra` with matching values.
  - Required: count saturates at 4; the first four pops hit the newest four addresses in LIFO order; the last two pops report `ras_miss` (empty).
- `req` and `eret` together with a D-stage JAL:
  - Required: next `f_pc=0x4180` and no push.
  - Next, `eret` with `epc=0x3040`: `f_pc=0x3040`.
- `stall` held for 3 cycles with a D-stage JAL:
  - Required: `f_pc` constant, then exactly one push after release.
  - Also: `reset` during the stall gives `f_pc=0x3000` and `ras_count=0`.
